// File: rtl/t08_wb_pkg.sv
// Shared types for the t08 Wishbone master and the memory handler that feeds it.
// Holds the FSM state encoding, default timeout and the request bundle.
package t08_wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBus,
    StErr
  } wb_state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;
  localparam int unsigned REQ_ADDR_W      = 32;
  localparam int unsigned REQ_DATA_W      = 32;

  typedef struct packed {
    logic                    we;
    logic [REQ_ADDR_W-1:0]   addr;
    logic [REQ_DATA_W-1:0]   wdata;
    logic [REQ_DATA_W/8-1:0] sel;
  } wb_req_t;

  // A full-word access must be word aligned; partial selects may land anywhere.
  function automatic logic word_misaligned(input logic sel_full, input logic [1:0] addr_lo);
    return sel_full && (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/t08_wb_master.sv
// Single-outstanding Wishbone classic master: one request per handshake, registered
// bus drive until ack or timeout, registered response with a one-cycle done pulse.
module t08_wb_master
  import t08_wb_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_sel,
  output logic                rsp_done,
  output logic                rsp_err,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]   wb_adr_o,
  output logic [DATA_W-1:0]   wb_dat_o,
  output logic [DATA_W/8-1:0] wb_sel_o,
  output logic                wb_we_o,
  output logic                wb_stb_o,
  output logic                wb_cyc_o,
  input  logic [DATA_W-1:0]   wb_dat_i,
  input  logic                wb_ack_i
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  wb_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;

  logic misaligned;
  logic terminal;

  assign misaligned = word_misaligned(&req_sel, req_addr[1:0]);
  assign terminal   = (cnt_q == CNT_LAST);

  // State register
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; ack takes priority over the terminal count.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = misaligned ? StErr : StBus;
        end
      end
      StBus: begin
        if (wb_ack_i || terminal) begin
          state_d = StIdle;
        end
      end
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture, timeout counter and response registers.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            adr_q <= req_addr;
            dat_q <= req_wdata;
            sel_q <= req_sel;
            we_q  <= req_we;
            cnt_q <= '0;
          end
        end
        StBus: begin
          if (wb_ack_i) begin
            done_q <= 1'b1;
            err_q  <= 1'b0;
            if (!we_q) begin
              rdata_q <= wb_dat_i;
            end
          end else if (terminal) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StErr: begin
          done_q  <= 1'b1;
          err_q   <= 1'b1;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state, so cyc/stb drop with an asynchronous reset.
  always_comb begin
    req_ready = 1'b0;
    wb_cyc_o  = 1'b0;
    wb_stb_o  = 1'b0;
    case (state_q)
      StIdle:  req_ready = 1'b1;
      StBus: begin
        wb_cyc_o = 1'b1;
        wb_stb_o = 1'b1;
      end
      default: ;
    endcase
  end

  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;
  assign wb_sel_o  = sel_q;
  assign wb_we_o   = we_q;
  assign rsp_done  = done_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_t08_wb_master.sv
// Directed bench for t08_wb_master: a small SRAM slave with programmable ack delay
// and hand-computed expectations for latency, data, errors and reset behaviour.
module tb_t08_wb_master;

  logic        clk = 1'b0;
  logic        nRst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_done;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_stb_o;
  logic        wb_cyc_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  // Slave model: ack on the ack_delay-th strobe cycle; 0 means never ack.
  int          ack_delay = 1;
  int          stb_cnt = 0;
  logic        spurious = 1'b0;
  logic [31:0] mem [16];

  t08_wb_master #(
    .ADDR_W        (32),
    .DATA_W        (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .nRst     (nRst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .req_sel  (req_sel),
    .rsp_done (rsp_done),
    .rsp_err  (rsp_err),
    .rsp_rdata(rsp_rdata),
    .wb_adr_o (wb_adr_o),
    .wb_dat_o (wb_dat_o),
    .wb_sel_o (wb_sel_o),
    .wb_we_o  (wb_we_o),
    .wb_stb_o (wb_stb_o),
    .wb_cyc_o (wb_cyc_o),
    .wb_dat_i (wb_dat_i),
    .wb_ack_i (wb_ack_i)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    logic [3:0] idx;
    idx = wb_adr_o[5:2];
    if (spurious) begin
      wb_ack_i = 1'b1;
    end else if (wb_cyc_o && wb_stb_o) begin
      stb_cnt = stb_cnt + 1;
      if (ack_delay != 0 && stb_cnt == ack_delay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = mem[idx];
        if (wb_we_o) begin
          for (int b = 0; b < 4; b++) begin
            if (wb_sel_o[b]) mem[idx][8*b +: 8] = wb_dat_o[8*b +: 8];
          end
        end
      end else begin
        wb_ack_i = 1'b0;
      end
    end else begin
      stb_cnt  = 0;
      wb_ack_i = 1'b0;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] sel);
    @(posedge clk); #1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_sel   = sel;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Cycle 1 is the cycle after the acceptance edge.
  task automatic run_xfer(input logic [31:0] exp_adr, output int done_cyc, output int cyc_cnt,
                          output logic adr_ok, output logic we_seen, output logic err,
                          output logic [31:0] rdata);
    done_cyc = -1;
    cyc_cnt  = 0;
    adr_ok   = 1'b1;
    we_seen  = 1'b0;
    err      = 1'b0;
    rdata    = '0;
    for (int k = 1; k <= 40 && done_cyc < 0; k++) begin
      @(negedge clk);
      if (wb_cyc_o) begin
        cyc_cnt++;
        if (wb_adr_o !== exp_adr) adr_ok = 1'b0;
        we_seen = wb_we_o;
      end
      if (rsp_done) begin
        done_cyc = k;
        err      = rsp_err;
        rdata    = rsp_rdata;
      end
    end
  endtask

  task automatic after_done(input string tag);
    @(negedge clk);
    check_eq({tag, "_done_single"}, 64'(rsp_done), 64'd0);
    check_eq({tag, "_ready"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          dc;
    int          cc;
    logic        ao;
    logic        ws;
    logic        er;
    logic [31:0] rd;
    int          seen;

    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[5] = 32'h1234_5678;

    #22 nRst = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 64'(req_ready), 64'd1);
    check_eq("rst_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    check_eq("rst_rsp", 64'({rsp_done, rsp_err, rsp_rdata}), 64'd0);
    check_eq("rst_bus", 64'({wb_we_o, wb_sel_o, wb_adr_o}), 64'd0);

    // Zero-wait write then read back.
    ack_delay = 1;
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    run_xfer(32'h10, dc, cc, ao, ws, er, rd);
    check_eq("wr0_done_cyc", 64'(dc), 64'd2);
    check_eq("wr0_stb_cycles", 64'(cc), 64'd1);
    check_eq("wr0_we", 64'(ws), 64'd1);
    check_eq("wr0_err", 64'(er), 64'd0);
    after_done("wr0");

    issue(1'b0, 32'h10, 32'h0, 4'hF);
    run_xfer(32'h10, dc, cc, ao, ws, er, rd);
    check_eq("rd0_done_cyc", 64'(dc), 64'd2);
    check_eq("rd0_we", 64'(ws), 64'd0);
    check_eq("rd0_rdata", 64'(rd), 64'hDEAD_BEEF);

    // Five-cycle ack delay.
    ack_delay = 5;
    issue(1'b0, 32'h14, 32'h0, 4'hF);
    run_xfer(32'h14, dc, cc, ao, ws, er, rd);
    check_eq("rd5_stb_cycles", 64'(cc), 64'd5);
    check_eq("rd5_adr_stable", 64'(ao), 64'd1);
    check_eq("rd5_done_cyc", 64'(dc), 64'd6);
    check_eq("rd5_rdata", 64'(rd), 64'h1234_5678);
    after_done("rd5");

    // A write must leave the previous read data in place.
    ack_delay = 1;
    issue(1'b1, 32'h18, 32'h0BAD_F00D, 4'hF);
    run_xfer(32'h18, dc, cc, ao, ws, er, rd);
    check_eq("wr1_rdata_held", 64'(rd), 64'h1234_5678);
    check_eq("wr1_err", 64'(er), 64'd0);

    // Slave never acks: timeout after 8 strobe cycles.
    ack_delay = 0;
    issue(1'b0, 32'h1C, 32'h0, 4'hF);
    run_xfer(32'h1C, dc, cc, ao, ws, er, rd);
    check_eq("to_stb_cycles", 64'(cc), 64'd8);
    check_eq("to_done_cyc", 64'(dc), 64'd9);
    check_eq("to_err", 64'(er), 64'd1);
    check_eq("to_rdata", 64'(rd), 64'd0);
    after_done("to");

    // Misaligned full-word write never reaches the bus.
    ack_delay = 1;
    issue(1'b1, 32'h2, 32'h5555_5555, 4'hF);
    run_xfer(32'h2, dc, cc, ao, ws, er, rd);
    check_eq("mis_cyc_cycles", 64'(cc), 64'd0);
    check_eq("mis_done_cyc", 64'(dc), 64'd2);
    check_eq("mis_err", 64'(er), 64'd1);
    after_done("mis");

    // Byte write to the same address is legal.
    issue(1'b1, 32'h2, 32'h00AB_0000, 4'h4);
    run_xfer(32'h2, dc, cc, ao, ws, er, rd);
    check_eq("byte_stb_cycles", 64'(cc), 64'd1);
    check_eq("byte_done_cyc", 64'(dc), 64'd2);
    check_eq("byte_err", 64'(er), 64'd0);
    issue(1'b0, 32'h0, 32'h0, 4'hF);
    run_xfer(32'h0, dc, cc, ao, ws, er, rd);
    check_eq("byte_readback", 64'(rd), 64'h00AB_0000);

    // Back-to-back with req_valid held; payload advances on each acceptance.
    @(posedge clk); #1;
    req_we    = 1'b0;
    req_sel   = 4'hF;
    req_addr  = 32'h10;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h14;
    @(negedge clk);
    check_eq("b2b_a_stb", 64'(wb_stb_o), 64'd1);
    check_eq("b2b_a_adr", 64'(wb_adr_o), 64'h10);
    check_eq("b2b_a_ready", 64'(req_ready), 64'd0);
    @(negedge clk);
    check_eq("b2b_a_done", 64'(rsp_done), 64'd1);
    check_eq("b2b_a_rdata", 64'(rsp_rdata), 64'hDEAD_BEEF);
    check_eq("b2b_a_ready_at_done", 64'(req_ready), 64'd1);
    check_eq("b2b_a_cyc_low", 64'(wb_cyc_o), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("b2b_b_stb", 64'(wb_stb_o), 64'd1);
    check_eq("b2b_b_adr", 64'(wb_adr_o), 64'h14);
    check_eq("b2b_b_no_done", 64'(rsp_done), 64'd0);
    @(negedge clk);
    check_eq("b2b_b_done", 64'(rsp_done), 64'd1);
    check_eq("b2b_b_rdata", 64'(rsp_rdata), 64'h1234_5678);

    // Spurious ack while idle.
    @(posedge clk); #1;
    spurious = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_done || wb_cyc_o) seen++;
    end
    check_eq("spur_no_activity", 64'(seen), 64'd0);
    @(posedge clk); #1;
    spurious = 1'b0;

    // Reset asserted while the strobe is high.
    ack_delay = 0;
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    @(negedge clk);
    check_eq("rstmid_stb_before", 64'(wb_stb_o), 64'd1);
    @(negedge clk);
    nRst = 1'b0;
    #1;
    check_eq("rstmid_cyc_stb", 64'({wb_cyc_o, wb_stb_o}), 64'd0);
    #2;
    nRst = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_done) seen++;
    end
    check_eq("rstmid_no_done", 64'(seen), 64'd0);
    check_eq("rstmid_ready", 64'(req_ready), 64'd1);
    ack_delay = 1;
    issue(1'b0, 32'h10, 32'h0, 4'hF);
    run_xfer(32'h10, dc, cc, ao, ws, er, rd);
    check_eq("rstmid_fresh_done_cyc", 64'(dc), 64'd2);
    check_eq("rstmid_fresh_rdata", 64'(rd), 64'hDEAD_BEEF);
    check_eq("rstmid_fresh_err", 64'(er), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
